event_irq_arbiter: RTL and testbench
====================================

Name: event_irq_arbiter

Overview:
- Shares one core interrupt line between NUM_SRC generic service units.
- Each service unit drives its irq_o into req_i; the block picks one source round-robin, presents it to the core with a request/acknowledge/done handshake, and blocks other sources until service completes or times out.
- Sits between the service-unit array and the core interrupt input.

Parameters:
- NUM_SRC, 4: number of service units (requesters); must be >= 2.
- ID_WIDTH, $clog2(NUM_SRC): width of the source index.
- TIMEOUT, 1024: maximum cycles in SERVE before forced release; 0 disables the timeout.
- CNT_WIDTH, 16: timeout counter width; must satisfy TIMEOUT < 2**CNT_WIDTH.

Ports:
- HCLK  in  1  clock; single clock domain.
- HRESET  in  1  asynchronous reset, active-high.
- req_i  in  NUM_SRC  level interrupt request per service unit (its irq_o).
- irq_o  out  1  interrupt request to core.
- irq_id_o  out  ID_WIDTH  index of the source currently presented or served.
- irq_ack_i  in  1  core accepts the presented interrupt; single-cycle pulse.
- irq_done_i  in  1  core finished servicing; single-cycle pulse.
- grant_o  out  NUM_SRC  one-hot grant; one-cycle pulse in the cycle after ack.
- busy_o  out  1  high while in SERVE.
- timeout_o  out  1  one-cycle pulse when SERVE is aborted by timeout.

Behaviour:
- Reset is HCLK, HRESET async active-high. It forces:
  - state IDLE
  - irq_o=0, irq_id_o=0, grant_o=0, busy_o=0, timeout_o=0
  - round-robin pointer ptr=0, counter=0
- All outputs are registered.
- FSM states: IDLE, REQ, SERVE.
- IDLE:
  - If req_i != 0, select the first set bit searching upward from ptr, wrapping NUM_SRC-1 -> 0.
  - Register the winner into irq_id_o, set irq_o=1, go to REQ.
  - Latency: req_i rising in cycle t gives irq_o=1 at the edge ending cycle t (visible in t+1).
  - If req_i == 0, stay in IDLE.
- REQ: irq_o and irq_id_o are held stable.
  - irq_ack_i=1: irq_o<=0, grant_o[irq_id_o]<=1 for one cycle, busy_o<=1, counter<=0, go to SERVE.
  - Else if req_i[irq_id_o]=0 (software cleared the pending bits): withdraw. irq_o<=0, go to IDLE; ptr is unchanged and no grant is issued.
  - Simultaneous ack and withdraw: ack wins.
  - Requests from other sources are ignored; no preemption.
- SERVE: busy_o=1, counter increments each cycle (saturating).
  - irq_done_i=1: busy_o<=0, ptr<=(irq_id_o+1) mod NUM_SRC, go to IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: timeout_o<=1 for one cycle, busy_o<=0, ptr advanced as for done, go to IDLE.
  - done and timeout in the same cycle: done wins, no timeout pulse.
- irq_done_i outside SERVE, and irq_ack_i outside REQ, are ignored. This includes a done arriving in the same cycle as the ack.
- After any return to IDLE, arbitration restarts next cycle. There is a minimum of one IDLE cycle between consecutive irq_o assertions.
- Fairness: with all sources permanently requesting and each serviced to done, grants cycle 0,1,...,NUM_SRC-1,0,...
- ptr wraps modulo NUM_SRC. For non-power-of-two NUM_SRC, ptr never takes values >= NUM_SRC.
- Reset mid-operation: immediate return to the reset state. Any in-flight interrupt is dropped; service units still hold their pending bits and re-request.
- Assertions:
  - grant_o is one-hot or zero.
  - irq_o and busy_o are never both high.
  - irq_id_o is stable while irq_o=1.

Test Plan:
- Reset with req_i=4'b1111 held → all outputs 0 during reset. After release, irq_o=1, irq_id_o=0 one cycle later.
- req_i=4'b1111 constant; each interrupt acked and done 3 cycles later → grant_o sequence 0001,0010,0100,1000,0001. irq_o low for at least 1 cycle between grants.
- req_i=4'b0100 raised, then dropped in REQ before ack → irq_o falls, no grant_o pulse, ptr stays 0. Next req_i=4'b0101 grants source 0.
- ack and req drop in the same cycle for source 2 → grant_o=4'b0100, busy_o=1.
- TIMEOUT=8, ack with no done → timeout_o pulses exactly 8 cycles after entering SERVE, busy_o falls, ptr advances. Variant: done on cycle 8 → no timeout pulse.
- HRESET asserted mid-SERVE for source 3 → busy_o=0 asynchronously. After release with req_i=4'b1000, irq_id_o=3 re-presented; ptr=0 after reset.

Source files
------------

// File: rtl/event_irq_arbiter.sv
// Round-robin arbiter that shares one core interrupt line between NUM_SRC service units,
// with a request/ack/done handshake and an optional service timeout.
module event_irq_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int ID_WIDTH  = $clog2(NUM_SRC),
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NUM_SRC-1:0]  req_i,
  output logic                irq_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic                irq_done_i,
  output logic [NUM_SRC-1:0]  grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

  localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_SRC - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);
  localparam bit                   TMO_EN   = (TIMEOUT != 0);

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 irq_d, busy_d, tmo_d;
  logic [ID_WIDTH-1:0]  id_d;
  logic [NUM_SRC-1:0]   grant_d;
  logic                 win_vld;
  logic [ID_WIDTH-1:0]  win_id;

  // First set request searching upward from ptr, wrapping at NUM_SRC-1; MSB flags a hit.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_SRC-1:0]  req,
                                                input logic [ID_WIDTH-1:0] ptr);
    logic                found;
    logic [ID_WIDTH-1:0] id;
    int                  idx;
    found = 1'b0;
    id    = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req[ID_WIDTH'(idx)]) begin
        found = 1'b1;
        id    = ID_WIDTH'(idx);
      end
    end
    return {found, id};
  endfunction

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // next-state and output decode
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    irq_d   = irq_o;
    id_d    = irq_id_o;
    busy_d  = busy_o;
    grant_d = '0;
    tmo_d   = 1'b0;
    {win_vld, win_id} = rr_pick(req_i, ptr_q);
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack beats a simultaneous withdraw; other sources never preempt.
        if (irq_ack_i) begin
          irq_d   = 1'b0;
          grant_d = NUM_SRC'(1) << irq_id_o;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SERVE;
        end else if (!req_i[irq_id_o]) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVE: begin
        cnt_d = sat_inc(cnt_q);
        if (irq_done_i) begin
          busy_d  = 1'b0;
          ptr_d   = next_id(irq_id_o);
          state_d = IDLE;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = next_id(irq_id_o);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      irq_o     <= irq_d;
      irq_id_o  <= id_d;
      grant_o   <= grant_d;
      busy_o    <= busy_d;
      timeout_o <= tmo_d;
    end
  end

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot0(grant_o));
  a_irq_busy_excl: assert property (@(posedge HCLK) disable iff (HRESET) !(irq_o && busy_o));
  a_id_stable: assert property (@(posedge HCLK) disable iff (HRESET)
                                (irq_o && $past(irq_o)) |-> $stable(irq_id_o));

endmodule

// File: tb/tb_event_irq_arbiter.sv
// Scoreboard bench for event_irq_arbiter: driver pushes expected events, a negedge monitor pops them.
module tb_event_irq_arbiter;
  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam int K_PRES = 0, K_GRANT = 1, K_TMO = 2;
  localparam int M_ACK = 0, M_ACKDROP = 1, M_WD = 2, M_TMO = 3;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [NS-1:0] req_i;
  logic          irq_o;
  logic [1:0]    irq_id_o;
  logic          irq_ack_i;
  logic          irq_done_i;
  logic [NS-1:0] grant_o;
  logic          busy_o;
  logic          timeout_o;

  always #5 HCLK = ~HCLK;

  event_irq_arbiter #(.NUM_SRC(NS), .ID_WIDTH(2), .TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .irq_o(irq_o), .irq_id_o(irq_id_o),
    .irq_ack_i(irq_ack_i), .irq_done_i(irq_done_i), .grant_o(grant_o), .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  typedef struct {int kind; int val;} exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;
  logic irq_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event with value %0h, none required (t=%0t)", name, val, $time);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check(name, val, e.val);
    end
  endtask

  // Reference rule: first requester at or above the pointer, wrapping.
  function automatic int pick(input int mask, input int p);
    for (int i = 0; i < NS; i++) begin
      if (((mask >> ((p + i) % NS)) & 1) != 0) return (p + i) % NS;
    end
    return -1;
  endfunction

  always @(negedge HCLK) begin
    if (HRESET) begin
      irq_prev = 1'b0;
    end else begin
      if (irq_o && !irq_prev) sb_pop("present_id", K_PRES, 32'(irq_id_o));
      if (grant_o != '0) begin
        sb_pop("grant", K_GRANT, 32'(grant_o));
        check("busy_with_grant", busy_o, 1);
      end
      if (timeout_o) begin
        sb_pop("timeout", K_TMO, 0);
        check("busy_after_tmo", busy_o, 0);
      end
      check("irq_busy_excl", irq_o && busy_o, 0);
      irq_prev = irq_o;
    end
  end

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic wait_irq(input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge HCLK);
      if (irq_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_irq: irq_o still 0 after %0d cycles, required 1", lim);
    end
  endtask

  // One complete transaction; called and returns on a negedge with the DUT idle.
  task automatic serve(input int mask, input int mode, input int dly);
    int w;
    int at;
    w = pick(mask, mptr);
    req_i = NS'(mask);
    expect_ev(K_PRES, w);
    wait_irq(6);
    if (mode == M_WD) begin
      req_i = '0;
      tick();
      check("withdraw_irq", irq_o, 0);
      tick();
      return;
    end
    irq_ack_i = 1'b1;
    if (mode == M_ACKDROP) req_i = '0;
    if (mode == M_ACK && $urandom_range(0, 3) == 0) irq_done_i = 1'b1;
    expect_ev(K_GRANT, 1 << w);
    tick();
    irq_ack_i  = 1'b0;
    irq_done_i = 1'b0;
    req_i      = '0;
    if (mode == M_TMO) begin
      at = 0;
      for (int i = 1; i <= 12 && at == 0; i++) begin
        if (timeout_o) at = i;
        else tick();
      end
      check("tmo_latency", at, TMO + 1);
      expect_ev(K_TMO, 0);
      mptr = (w + 1) % NS;
      tick();
    end else begin
      for (int i = 1; i < dly; i++) tick();
      irq_done_i = 1'b1;
      tick();
      irq_done_i = 1'b0;
      check("busy_after_done", busy_o, 0);
      mptr = (w + 1) % NS;
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    int w;
    HRESET     = 1'b1;
    req_i      = 4'b1111;
    irq_ack_i  = 1'b0;
    irq_done_i = 1'b0;
    repeat (3) tick();
    check("rst_irq", irq_o, 0);
    check("rst_id", irq_id_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_tmo", timeout_o, 0);
    expect_ev(K_PRES, 0);
    HRESET = 1'b0;
    mptr   = 0;
    wait_irq(2);
    check("post_rst_id", irq_id_o, 0);

    // All sources requesting continuously: grants rotate 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      w = g % NS;
      check("fair_id", irq_id_o, w);
      irq_ack_i = 1'b1;
      expect_ev(K_GRANT, 1 << w);
      tick();
      irq_ack_i = 1'b0;
      if (g == 4) req_i = '0;
      tick();
      tick();
      irq_done_i = 1'b1;
      if (g < 4) expect_ev(K_PRES, (w + 1) % NS);
      tick();
      irq_done_i = 1'b0;
      mptr = (w + 1) % NS;
      check("gap_irq_low", irq_o, 0);
      if (g < 4) wait_irq(3);
    end
    tick();

    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    mptr   = 0;
    tick();
    serve(4'b0100, M_WD, 0);
    serve(4'b0101, M_ACK, 3);
    serve(4'b0100, M_ACKDROP, 2);
    serve(4'b1000, M_TMO, 0);
    serve(4'b0001, M_ACK, 8);

    for (int n = 0; n < 40; n++) begin
      serve($urandom_range(1, 15), $urandom_range(0, 3), $urandom_range(1, 8));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset while source 3 is in service.
    req_i = 4'b1000;
    expect_ev(K_PRES, 3);
    wait_irq(6);
    irq_ack_i = 1'b1;
    expect_ev(K_GRANT, 4'b1000);
    tick();
    irq_ack_i = 1'b0;
    tick();
    #2 HRESET = 1'b1;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_irq", irq_o, 0);
    check("async_rst_grant", grant_o, 0);
    mptr = 0;
    tick();
    expect_ev(K_PRES, 3);
    HRESET = 1'b0;
    wait_irq(2);
    check("rerequest_id", irq_id_o, 3);
    req_i = '0;
    tick();
    tick();
    check("rerequest_withdraw", irq_o, 0);
    serve(4'b1111, M_ACKDROP, 2);

    repeat (4) tick();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
